reg_pipe_bank: RTL and testbench

//  Parametrised multi-channel elastic register pipeline; successor to the fixed 3-bit

---
 rtl/reg_pipe_pkg.sv | 21 ++
 rtl/reg_pipe_stage.sv | 34 +++
 rtl/reg_pipe_bank.sv | 93 +++++++++
 tb/tb_reg_pipe_bank.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/reg_pipe_pkg.sv
// Shared helpers for the reg_pipe family: width arithmetic and the default
// per-channel reset value.
package reg_pipe_pkg;

  localparam int DEF_RST_VAL = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Bits needed to hold 0..depth, never less than one.
  function automatic int cnt_width(input int depth);
    return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One elastic valid/data register stage. It can load whenever it is empty or the
// stage downstream can take its current entry.
module reg_pipe_stage #(
  parameter int             W        = 9,
  parameter logic [W-1:0]   RST_WORD = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         dn_ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         rdy
);

  assign rdy = ~valid | dn_ready;

  // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      // NOTE: data is reset too, so out_data shows the programmed reset word after rst.
      data  <= RST_WORD;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (rdy) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/reg_pipe_bank.sv
// Multi-channel elastic register pipeline: DEPTH valid/ready stages with bubble
// collapsing, flush, programmable reset word and an in-flight occupancy count.
module reg_pipe_bank
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH   = 3,
  parameter int               NCH     = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH*NCH-1:0]          in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH*NCH-1:0]          out_data,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int             W        = WIDTH * NCH;
  localparam int             CW       = cnt_width(DEPTH);
  localparam logic [W-1:0]   RST_WORD = {NCH{RST_VAL}};

  logic           accept;
  logic           pop;
  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]   data_q [DEPTH];
  logic [CW-1:0]  count_q;

  // Each stage keeps its own rdy so the combinational ready chain runs stage to
  // stage from out_ready back to the input without a self-referencing vector.
  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    logic         rdy;
    logic         up_valid;
    logic [W-1:0] up_data;
    logic         dn_ready;

    if (s == 0) begin : g_head
      assign up_valid = accept;
      assign up_data  = in_data;
    end else begin : g_body
      assign up_valid = valid_q[s-1];
      assign up_data  = data_q[s-1];
    end

    if (s == DEPTH - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_mid
      assign dn_ready = g_stage[s+1].rdy;
    end

    reg_pipe_stage #(
      .W        (W),
      .RST_WORD (RST_WORD)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (up_valid),
      .up_data  (up_data),
      .dn_ready (dn_ready),
      .valid    (valid_q[s]),
      .data     (data_q[s]),
      .rdy      (rdy)
    );
  end

  assign in_ready  = g_stage[0].rdy & ~flush & ~rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  // A pop during flush is legal but the entry is simply gone; count restarts at zero.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q <= '0;
    end else if (accept && !pop) begin
      count_q <= count_q + CW'(1);
    end else if (pop && !accept) begin
      count_q <= count_q - CW'(1);
    end
  end

  a_count_matches_valid: assert property (
    @(posedge clk) disable iff (rst) count_q == CW'($countones(valid_q))
  );

endmodule

// File: tb/tb_reg_pipe_bank.sv
// Scoreboard bench for reg_pipe_bank: a queue-based model predicts acceptance,
// occupancy, output timing and order; two builds differ only in RST_VAL.
module tb_reg_pipe_bank;

  localparam int WIDTH = 3;
  localparam int NCH   = 3;
  localparam int DEPTH = 2;
  localparam int W     = WIDTH * NCH;
  localparam int CW    = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;

  logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [W-1:0]  a_out_data, b_out_data;
  logic [CW-1:0] a_count, b_count;

  reg_pipe_bank #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .RST_VAL(3'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  reg_pipe_bank #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .RST_VAL(3'h5)) dut_rv (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .count(b_count)
  );

  typedef struct {
    logic [W-1:0] data;
    int           vis;   // first cycle this entry may be presented at the output
  } entry_t;

  entry_t exp_q[$];
  int     cyc    = 0;
  int     errors = 0;
  int     checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model side: in-flight entries are whatever the queue holds; the pipe is full
  // when it holds DEPTH of them. Accepted words are pushed with their earliest
  // output cycle (DEPTH cycles later).
  always @(negedge clk) begin : model
    logic exp_rdy;
    exp_rdy = !rst && !flush && ((exp_q.size() < DEPTH) || out_ready);
    check("in_ready",    32'(a_in_ready), 32'(exp_rdy));
    check("in_ready_rv", 32'(b_in_ready), 32'(exp_rdy));
    check("count",       32'(a_count), 32'(exp_q.size()));
    check("count_rv",    32'(b_count), 32'(exp_q.size()));
    if (in_valid && exp_rdy) exp_q.push_back('{data: in_data, vis: cyc + DEPTH});
  end

  // Monitor side: the head entry must be on the output once its cycle arrives;
  // a pop lets the next entry show no earlier than the following cycle.
  always @(negedge clk) begin : monitor
    bit exp_valid;
    #1;
    exp_valid = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
    check("out_valid",    32'(a_out_valid), 32'(exp_valid));
    check("out_valid_rv", 32'(b_out_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("out_data",    32'(a_out_data), 32'(exp_q[0].data));
      check("out_data_rv", 32'(b_out_data), 32'(exp_q[0].data));
      if (out_ready && !rst) begin
        void'(exp_q.pop_front());
        if (exp_q.size() > 0 && exp_q[0].vis < cyc + 1) exp_q[0].vis = cyc + 1;
      end
    end
    if (rst || flush) exp_q.delete();
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy,
                       input logic fl, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
  endtask

  initial begin
    // Reset held two cycles, then reset words on both builds.
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); #2;
    check("rst_out_data",    32'(a_out_data), 32'h000);
    check("rst_out_data_rv", 32'(b_out_data), 32'h16D);

    // Single word through an empty pipe.
    drive(1'b1, 9'h1A5, 1'b1, 1'b0, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Back-to-back stream 1..5.
    for (int i = 1; i <= 5; i++) drive(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Fill while stalled, then simultaneous pop and push when full.
    drive(1'b1, 9'h011, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'h022, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'h033, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'h033, 1'b1, 1'b0, 1'b0);
    repeat (4) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush with two entries in flight and a producer still offering data.
    drive(1'b1, 9'h0AA, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'h0BB, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'h0CC, 1'b0, 1'b1, 1'b0);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream with a full pipe and in_valid high.
    drive(1'b1, 9'h0DD, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'h0EE, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 9'h0FF, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #2;
    check("midrst_out_data",    32'(a_out_data), 32'h000);
    check("midrst_out_data_rv", 32'(b_out_data), 32'h16D);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
    end

    // Drain.
    repeat (DEPTH + 3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
